// File: rtl/hall_pkg.sv
// Shared Hall-sensor constants: code-to-sector table, illegal codes and
// sector arithmetic used by the conditioner.
package hall_pkg;

    localparam int unsigned SEC_W       = 3;
    localparam int unsigned NUM_SECTORS = 6;

    typedef logic [SEC_W-1:0] hall_code_t;
    typedef logic [SEC_W-1:0] sector_t;

    typedef enum logic [1:0] {
        SEQ_FWD,
        SEQ_REV,
        SEQ_SKIP
    } seq_e;

    localparam hall_code_t HALL_INV_LO = 3'b000;
    localparam hall_code_t HALL_INV_HI = 3'b111;

    // Entry i is the Hall code for sector i; ascending index is forward rotation.
    localparam logic [NUM_SECTORS-1:0][SEC_W-1:0] SECTOR_LUT =
        {3'b110, 3'b010, 3'b011, 3'b001, 3'b101, 3'b100};

    function automatic logic code_is_valid(hall_code_t c);
        return (c != HALL_INV_LO) && (c != HALL_INV_HI);
    endfunction

    function automatic sector_t code_to_sector(hall_code_t c);
        sector_t s;
        s = '0;
        for (int unsigned i = 0; i < NUM_SECTORS; i++) begin
            if (SECTOR_LUT[i] == c) s = sector_t'(i);
        end
        return s;
    endfunction

    function automatic sector_t sector_inc(sector_t s);
        return (s == sector_t'(NUM_SECTORS - 1)) ? '0 : s + 1'b1;
    endfunction

    function automatic sector_t sector_dec(sector_t s);
        return (s == '0) ? sector_t'(NUM_SECTORS - 1) : s - 1'b1;
    endfunction

    function automatic seq_e classify_step(sector_t old_s, sector_t new_s);
        if (new_s == sector_inc(old_s)) return SEQ_FWD;
        if (new_s == sector_dec(old_s)) return SEQ_REV;
        return SEQ_SKIP;
    endfunction

endpackage

// File: rtl/hall_filter.sv
// Two-flop synchronizer and run-length debounce for the Hall input vector.
// upd_o/next_o announce the code that hall_o takes on the coming edge.
module hall_filter
    import hall_pkg::*;
#(
    parameter int unsigned FILT_LEN = 4,
    parameter int unsigned W        = SEC_W
) (
    input  logic         clk_i,
    input  logic         rst_ni,
    input  logic [W-1:0] hall_i,
    output logic [W-1:0] hall_o,
    output logic         upd_o,
    output logic [W-1:0] next_o
);

    // run_q holds (consecutive equal samples - 1), saturating at FILT_LEN-1.
    localparam logic [7:0] RUN_MAX = 8'(FILT_LEN - 1);

    logic [W-1:0] sync1_q, sync2_q, cand_q, code_q;
    logic [7:0]   run_q, run_d;

    always_comb begin
        run_d = '0;
        if (sync2_q == cand_q) begin
            run_d = (run_q >= RUN_MAX) ? RUN_MAX : run_q + 8'd1;
        end
        upd_o  = (run_d == RUN_MAX) && (sync2_q != code_q);
        next_o = sync2_q;
    end

    assign hall_o = code_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q <= '0;
            sync2_q <= '0;
            cand_q  <= '0;
            run_q   <= '0;
            code_q  <= '0;
        end else begin
            sync1_q <= hall_i;
            sync2_q <= sync1_q;
            cand_q  <= sync2_q;
            run_q   <= run_d;
            if (upd_o) code_q <= sync2_q;
        end
    end

endmodule

// File: rtl/hall_conditioner.sv
// BLDC Hall-sensor conditioner: debounced code, sector decode, direction,
// edge-period measurement, stall detection and sticky fault flags.
module hall_conditioner
    import hall_pkg::*;
#(
    parameter int unsigned FILT_LEN = 4,
    parameter int unsigned CNT_W    = 24,
    parameter int unsigned TIMEOUT  = 2**24 - 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [2:0]       hall_in,
    input  logic             fault_clr,
    output logic [2:0]       hall_q,
    output logic [2:0]       sector,
    output logic             sector_valid,
    output logic             edge_stb,
    output logic             dir,
    output logic [CNT_W-1:0] period,
    output logic             period_valid,
    output logic             fault_code,
    output logic             fault_seq,
    output logic             stall
);

    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);

    logic       upd;
    hall_code_t code_next;

    hall_filter #(
        .FILT_LEN (FILT_LEN),
        .W        (SEC_W)
    ) u_filter (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .hall_i (hall_in),
        .hall_o (hall_q),
        .upd_o  (upd),
        .next_o (code_next)
    );

    sector_t    sector_q, sector_d, new_sec;
    logic       sv_q, sv_d, edge_q, dir_q, dir_d;
    logic       pv_q, pv_d, stall_q, stall_d, have_q, have_d;
    logic       fc_q, fc_d, fs_q, fs_d;
    logic       new_valid, vedge, code_ev, seq_ev;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc, period_q, period_d;
    seq_e       step;

    always_comb begin
        new_valid = code_is_valid(code_next);
        new_sec   = code_to_sector(code_next);
        vedge     = upd && new_valid;
        step      = classify_step(sector_q, new_sec);
        cnt_inc   = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;

        sector_d  = sector_q;
        sv_d      = sv_q;
        dir_d     = dir_q;
        period_d  = period_q;
        pv_d      = pv_q;
        stall_d   = stall_q;
        have_d    = have_q;
        cnt_d     = cnt_inc;
        code_ev   = upd && !new_valid;
        seq_ev    = 1'b0;

        if (vedge) begin
            sector_d = new_sec;
            sv_d     = 1'b1;
            period_d = cnt_inc;
            pv_d     = have_q && !stall_q;
            stall_d  = 1'b0;
            have_d   = 1'b1;
            cnt_d    = '0;
            // Direction only judged between two legal codes; sv_q low covers
            // both the first code after reset and recovery from 000/111.
            if (sv_q) begin
                case (step)
                    SEQ_FWD: dir_d  = 1'b1;
                    SEQ_REV: dir_d  = 1'b0;
                    default: seq_ev = 1'b1;
                endcase
            end
        end else begin
            if (upd) sv_d = 1'b0;
            if (cnt_inc >= TIMEOUT_C) begin
                stall_d = 1'b1;
                pv_d    = 1'b0;
            end
        end

        fc_d = code_ev || (fc_q && !fault_clr);
        fs_d = seq_ev  || (fs_q && !fault_clr);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sector_q <= '0;
            sv_q     <= 1'b0;
            edge_q   <= 1'b0;
            dir_q    <= 1'b1;
            period_q <= '0;
            pv_q     <= 1'b0;
            stall_q  <= 1'b0;
            have_q   <= 1'b0;
            cnt_q    <= '0;
            fc_q     <= 1'b0;
            fs_q     <= 1'b0;
        end else begin
            sector_q <= sector_d;
            sv_q     <= sv_d;
            edge_q   <= upd;
            dir_q    <= dir_d;
            period_q <= period_d;
            pv_q     <= pv_d;
            stall_q  <= stall_d;
            have_q   <= have_d;
            cnt_q    <= cnt_d;
            fc_q     <= fc_d;
            fs_q     <= fs_d;
        end
    end

    assign sector       = sector_q;
    assign sector_valid = sv_q;
    assign edge_stb     = edge_q;
    assign dir          = dir_q;
    assign period       = period_q;
    assign period_valid = pv_q;
    assign stall        = stall_q;
    assign fault_code   = fc_q;
    assign fault_seq    = fs_q;

endmodule

// File: tb/tb_hall_conditioner.sv
// Randomised and directed bench for hall_conditioner against a sliding-window,
// timestamp-based reference model.
module tb_hall_conditioner;

    localparam int unsigned FILT = 4;
    localparam int unsigned CW   = 16;
    localparam int unsigned TMO  = 1000;
    localparam int          PMAX = (1 << CW) - 1;

    localparam logic [2:0] FWD_TBL [6] = '{3'b100, 3'b101, 3'b001, 3'b011, 3'b010, 3'b110};

    logic          clk, rst_n, fault_clr;
    logic [2:0]    hall_in, hall_q, sector;
    logic          sector_valid, edge_stb, dir, period_valid, fault_code, fault_seq, stall;
    logic [CW-1:0] period;

    hall_conditioner #(
        .FILT_LEN (FILT),
        .CNT_W    (CW),
        .TIMEOUT  (TMO)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .hall_in      (hall_in),
        .fault_clr    (fault_clr),
        .hall_q       (hall_q),
        .sector       (sector),
        .sector_valid (sector_valid),
        .edge_stb     (edge_stb),
        .dir          (dir),
        .period       (period),
        .period_valid (period_valid),
        .fault_code   (fault_code),
        .fault_seq    (fault_seq),
        .stall        (stall)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int sec_idx(input logic [2:0] c);
        for (int i = 0; i < 6; i++) if (FWD_TBL[i] == c) return i;
        return -1;
    endfunction

    // Reference model state
    logic [2:0] raw[$];
    logic [2:0] win[$];
    logic [2:0] m_hall;
    int         m_sec, m_period, cyc, last;
    bit         m_sv, m_edge, m_dir, m_pv, m_fc, m_fs, m_stall, have;

    task automatic model_reset();
        raw = '{3'b000, 3'b000};
        win = '{3'b000};
        m_hall = 3'b000; m_sec = 0; m_period = 0; cyc = 0; last = 0;
        m_sv = 0; m_edge = 0; m_dir = 1; m_pv = 0; m_fc = 0; m_fs = 0;
        m_stall = 0; have = 0;
    endtask

    task automatic model_step();
        logic [2:0] v;
        int  ni, oi;
        bit  load, all_eq, vedge, ec, es;
        cyc++;
        v = raw.pop_front();
        raw.push_back(hall_in);
        win.push_back(v);
        if (win.size() > FILT) void'(win.pop_front());
        all_eq = (win.size() == FILT);
        foreach (win[i]) if (win[i] != v) all_eq = 0;
        load = all_eq && (v != m_hall);
        ni = sec_idx(v);
        oi = sec_idx(m_hall);
        vedge = load && (ni >= 0);
        ec = load && (ni < 0);
        es = 0;
        m_edge = load;
        if (vedge) begin
            if (oi >= 0) begin
                if (ni == (oi + 1) % 6)      m_dir = 1;
                else if (ni == (oi + 5) % 6) m_dir = 0;
                else                         es = 1;
            end
            m_sec    = ni;
            m_sv     = 1;
            m_period = (cyc - last > PMAX) ? PMAX : cyc - last;
            m_pv     = have && !m_stall;
            m_stall  = 0;
            have     = 1;
            last     = cyc;
        end else begin
            if (load) m_sv = 0;
            if (cyc - last >= int'(TMO)) begin
                m_stall = 1;
                m_pv    = 0;
            end
        end
        if (load) m_hall = v;
        m_fc = ec || (m_fc && !fault_clr);
        m_fs = es || (m_fs && !fault_clr);
    endtask

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) model_reset();
            else        model_step();
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                check_eq("hall_q",       32'(hall_q),       32'(m_hall));
                check_eq("sector",       32'(sector),       32'(m_sec));
                check_eq("sector_valid", 32'(sector_valid), 32'(m_sv));
                check_eq("edge_stb",     32'(edge_stb),     32'(m_edge));
                check_eq("dir",          32'(dir),          32'(m_dir));
                check_eq("period",       32'(period),       32'(m_period));
                check_eq("period_valid", 32'(period_valid), 32'(m_pv));
                check_eq("fault_code",   32'(fault_code),   32'(m_fc));
                check_eq("fault_seq",    32'(fault_seq),    32'(m_fs));
                check_eq("stall",        32'(stall),        32'(m_stall));
            end
        end
    end

    // Called at a negedge; applies reset, checks reset values, releases.
    task automatic do_reset();
        chk_en = 1'b0;
        rst_n  = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check_eq("rst_hall_q",       32'(hall_q),       32'h0);
        check_eq("rst_sector",       32'(sector),       32'h0);
        check_eq("rst_sector_valid", 32'(sector_valid), 32'h0);
        check_eq("rst_edge_stb",     32'(edge_stb),     32'h0);
        check_eq("rst_dir",          32'(dir),          32'h1);
        check_eq("rst_period",       32'(period),       32'h0);
        check_eq("rst_period_valid", 32'(period_valid), 32'h0);
        check_eq("rst_faults",       32'({fault_code, fault_seq}), 32'h0);
        check_eq("rst_stall",        32'(stall),        32'h0);
        rst_n  = 1'b1;
        chk_en = 1'b1;
    endtask

    // Called at a negedge; holds v for n edges, fault_clr high before edge clr_at.
    task automatic drive(input logic [2:0] v, input int n, input int clr_at);
        hall_in = v;
        for (int i = 1; i <= n; i++) begin
            fault_clr = (i == clr_at);
            @(negedge clk);
        end
        fault_clr = 1'b0;
    endtask

    initial begin
        int cur, r, dw, ca;
        logic [2:0] code;
        rst_n = 1'b0; fault_clr = 1'b0; hall_in = 3'b100;
        @(negedge clk);
        do_reset();

        // Power-up acceptance of 100
        repeat (5) @(negedge clk);
        check_eq("pwr_hall_q_early", 32'(hall_q), 32'h0);
        @(negedge clk);
        check_eq("pwr_hall_q",   32'(hall_q),       32'h4);
        check_eq("pwr_edge_stb", 32'(edge_stb),     32'h1);
        check_eq("pwr_sv",       32'(sector_valid), 32'h1);
        check_eq("pwr_pv",       32'(period_valid), 32'h0);
        repeat (94) @(negedge clk);

        // Forward rotation, ending in sector 5
        for (int i = 1; i <= 11; i++) drive(FWD_TBL[i % 6], 100, 0);
        check_eq("fwd_period", 32'(period), 32'd100);
        check_eq("fwd_dir",    32'(dir),    32'h1);
        check_eq("fwd_pv",     32'(period_valid), 32'h1);

        // Reverse 110 -> 010 -> 011
        drive(3'b010, 100, 0);
        drive(3'b011, 100, 0);
        check_eq("rev_dir",  32'(dir),       32'h0);
        check_eq("rev_fseq", 32'(fault_seq), 32'h0);

        // Glitches on H_2
        drive(3'b001, 3, 0);
        drive(3'b011, 40, 0);
        check_eq("glitch3_hall_q", 32'(hall_q), 32'h3);
        drive(3'b001, 4, 0);
        drive(3'b011, 40, 0);

        // Skip, illegal code, clear; then clear coinciding with a new fault
        drive(3'b100, 50, 30);
        drive(3'b001, 50, 0);
        check_eq("skip_fseq", 32'(fault_seq), 32'h1);
        drive(3'b111, 50, 0);
        check_eq("inv_fcode", 32'(fault_code), 32'h1);
        check_eq("inv_sv",    32'(sector_valid), 32'h0);
        drive(3'b111, 20, 5);
        check_eq("clr_faults", 32'({fault_code, fault_seq}), 32'h0);
        drive(3'b000, 30, FILT + 2);

        // Stall and recovery
        drive(3'b100, 1200, 0);
        check_eq("stall_set", 32'(stall), 32'h1);
        drive(3'b101, 100, 0);
        check_eq("stall_clr", 32'(stall), 32'h0);
        check_eq("stall_pv0", 32'(period_valid), 32'h0);
        drive(3'b001, 100, 0);
        check_eq("stall_pv1", 32'(period_valid), 32'h1);
        check_eq("stall_period", 32'(period), 32'd100);

        // Random walk with glitches, illegal codes and clears
        cur = 2;
        for (int i = 0; i < 300; i++) begin
            r = $urandom_range(0, 9);
            if (r < 4)      code = FWD_TBL[(cur + 1) % 6];
            else if (r < 7) code = FWD_TBL[(cur + 5) % 6];
            else if (r < 9) code = FWD_TBL[$urandom_range(0, 5)];
            else            code = 3'($urandom_range(0, 7));
            if (sec_idx(code) >= 0) cur = sec_idx(code);
            dw = ($urandom_range(0, 5) == 0) ? 20 : $urandom_range(1, 10);
            ca = ($urandom_range(0, 7) == 0) ? $urandom_range(1, dw) : 0;
            drive(code, dw, ca);
            if (i == 150) begin
                drive(FWD_TBL[(cur + 1) % 6], 3, 0);
                do_reset();
            end
        end
        drive(hall_in, 30, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
